// File: rtl/prio_pkg.sv
// Shared definitions for the priority grant decoder slice.
//   DEFAULT_WIDTH / DEFAULT_IDX_W : default grant vector width and index width
//   prio_idx_t, grant_vec_t       : index and one-hot grant types at the defaults
//   grant_state_e                 : grant FSM states
//   max3()                        : helper for sizing the hold/gap counter
package prio_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_IDX_W = 3;

  typedef logic [DEFAULT_IDX_W-1:0] prio_idx_t;
  typedef logic [DEFAULT_WIDTH-1:0] grant_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } grant_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/priority_grant_decoder_onehot_decode.sv
// Combinational index -> one-hot decoder with an in-range flag.
//   idx      : encoded index
//   onehot   : (1 << idx) when idx < WIDTH, otherwise all zero
//   in_range : idx < WIDTH
// Outputs are not registered here; the parent registers what it drives.
module onehot_decode
  import prio_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDX_W = DEFAULT_IDX_W
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot,
  output logic             in_range
);

  // Compare every line against the index rather than indexing onehot[idx],
  // so a non-power-of-2 WIDTH never produces an out-of-bounds select.
  always_comb begin
    in_range = (32'(idx) < WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      onehot[i] = (32'(idx) == i);
    end
  end

endmodule

// File: rtl/priority_grant_decoder.sv
// Timed one-hot grant driver: the inverse of the 8:3 priority encoder.
//   clk, rst     : clock and synchronous active-high reset
//   in_priority  : encoded index, taken when in_valid && in_ready
//   in_valid     : in_priority is valid
//   in_ready     : pending slot is empty and not in reset
//   out_onehot   : registered one-hot grant, zero outside DRIVE
//   out_valid    : out_onehot carries an active grant
//   busy         : FSM not IDLE, or an index is pending
//   err          : one-cycle pulse after an out-of-range index was dropped
// Each accepted index is driven for HOLD_CYCLES cycles, followed by
// GAP_CYCLES all-zero cycles. One extra index can be queued while busy.
module priority_grant_decoder
  import prio_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int IDX_W       = DEFAULT_IDX_W,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] in_priority,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, 2));
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  grant_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic             pend_full_q, pend_full_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

  logic [WIDTH-1:0] out_onehot_d;
  logic             out_valid_d, busy_d, err_d;

  logic             xfer, take, take_direct, load_next;
  logic [WIDTH-1:0] in_onehot_unused_sink, cur_onehot;
  logic             in_in_range, cur_in_range;

  // Range check on the incoming index.
  onehot_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_in_decode (
    .idx      (in_priority),
    .onehot   (in_onehot_unused_sink),
    .in_range (in_in_range)
  );

  // One-hot of the index that will be driven after this edge.
  onehot_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_cur_decode (
    .idx      (cur_d),
    .onehot   (cur_onehot),
    .in_range (cur_in_range)
  );

  assign in_ready = !rst && !pend_full_q;
  assign xfer     = in_valid && in_ready;
  // Out-of-range indices complete the handshake but never reach the FSM.
  assign take     = xfer && in_in_range;

  // Next-state logic.
  // NOTE: every variable assigned in an always_comb gets a default first,
  // otherwise a path that skips it infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pend_full_d = pend_full_q;
    pend_idx_d  = pend_idx_q;
    take_direct = 1'b0;
    load_next   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d     = DRIVE;
          cnt_d       = HOLD_LOAD;
          cur_d       = in_priority;
          take_direct = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          load_next = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             load_next = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // End of a grant (or gap): start the queued index if any. An index
    // arriving on this very edge with the slot empty starts directly, so it
    // is never stranded in the slot while the FSM sits in IDLE.
    if (load_next) begin
      if (pend_full_q) begin
        state_d     = DRIVE;
        cnt_d       = HOLD_LOAD;
        cur_d       = pend_idx_q;
        pend_full_d = 1'b0;
      end else if (take) begin
        state_d     = DRIVE;
        cnt_d       = HOLD_LOAD;
        cur_d       = in_priority;
        take_direct = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

    if (take && !take_direct) begin
      pend_full_d = 1'b1;
      pend_idx_d  = in_priority;
    end
  end

  // Output logic: computed from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    out_valid_d  = (state_d == DRIVE) && cur_in_range;
    out_onehot_d = out_valid_d ? cur_onehot : '0;
    busy_d       = (state_d != IDLE) || pend_full_d;
    err_d        = xfer && !in_in_range;
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      pend_full_q <= 1'b0;
      pend_idx_q  <= '0;
      out_onehot  <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      pend_full_q <= pend_full_d;
      pend_idx_q  <= pend_idx_d;
      out_onehot  <= out_onehot_d;
      out_valid   <= out_valid_d;
      busy        <= busy_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Self-checking bench for priority_grant_decoder: default config,
// a GAP_CYCLES=0 config and a WIDTH=6 config run side by side.
module tb_priority_grant_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default: WIDTH=8, HOLD=4, GAP=1
  logic [2:0] d_pri;
  logic       d_valid, d_ready, d_ovalid, d_busy, d_err;
  logic [7:0] d_onehot;
  // GAP_CYCLES=0
  logic [2:0] g_pri;
  logic       g_valid, g_ready, g_ovalid, g_busy, g_err;
  logic [7:0] g_onehot;
  // WIDTH=6
  logic [2:0] w_pri;
  logic       w_valid, w_ready, w_ovalid, w_busy, w_err;
  logic [5:0] w_onehot;

  priority_grant_decoder u_dut (
    .clk(clk), .rst(rst), .in_priority(d_pri), .in_valid(d_valid), .in_ready(d_ready),
    .out_onehot(d_onehot), .out_valid(d_ovalid), .busy(d_busy), .err(d_err)
  );

  priority_grant_decoder #(.GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .rst(rst), .in_priority(g_pri), .in_valid(g_valid), .in_ready(g_ready),
    .out_onehot(g_onehot), .out_valid(g_ovalid), .busy(g_busy), .err(g_err)
  );

  priority_grant_decoder #(.WIDTH(6), .IDX_W(3)) u_w6 (
    .clk(clk), .rst(rst), .in_priority(w_pri), .in_valid(w_valid), .in_ready(w_ready),
    .out_onehot(w_onehot), .out_valid(w_ovalid), .busy(w_busy), .err(w_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0] idx;
    logic [7:0] exp_onehot;
  } vec_t;

  vec_t vecs[8];

  // Expected out_onehot on the cycles following the first transfer.
  logic [7:0] exp_t2[11] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00,
                             8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
  logic [7:0] exp_t3[9]  = '{8'h02, 8'h02, 8'h02, 8'h02,
                             8'h40, 8'h40, 8'h40, 8'h40, 8'h00};

  logic [2:0] sb_q[$];
  logic [7:0] cur_exp;
  int         run_len, grants, accepted;

  initial begin
    vecs[0] = '{idx: 3'd0, exp_onehot: 8'h01};
    vecs[1] = '{idx: 3'd1, exp_onehot: 8'h02};
    vecs[2] = '{idx: 3'd2, exp_onehot: 8'h04};
    vecs[3] = '{idx: 3'd3, exp_onehot: 8'h08};
    vecs[4] = '{idx: 3'd4, exp_onehot: 8'h10};
    vecs[5] = '{idx: 3'd5, exp_onehot: 8'h20};
    vecs[6] = '{idx: 3'd6, exp_onehot: 8'h40};
    vecs[7] = '{idx: 3'd7, exp_onehot: 8'h80};

    rst = 1'b1;
    d_pri = '0; d_valid = 1'b0;
    g_pri = '0; g_valid = 1'b0;
    w_pri = '0; w_valid = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ready",  32'(d_ready),  0);
    check("rst_onehot", 32'(d_onehot), 0);
    check("rst_valid",  32'(d_ovalid), 0);
    check("rst_busy",   32'(d_busy),   0);
    check("rst_err",    32'(d_err),    0);
    check("rst_g_ready", 32'(g_ready), 0);
    check("rst_w_ready", 32'(w_ready), 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(d_ready), 1);

    // 1. Sweep every index from IDLE
    for (int v = 0; v < 8; v++) begin
      d_valid = 1'b1;
      d_pri   = vecs[v].idx;
      tick();
      d_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t1_onehot_i%0d_c%0d", v, k), 32'(d_onehot), 32'(vecs[v].exp_onehot));
        check($sformatf("t1_valid_i%0d_c%0d", v, k),  32'(d_ovalid), 1);
        check($sformatf("t1_err_i%0d_c%0d", v, k),    32'(d_err),    0);
        tick();
      end
      check($sformatf("t1_gap_onehot_i%0d", v), 32'(d_onehot), 0);
      check($sformatf("t1_gap_valid_i%0d", v),  32'(d_ovalid), 0);
      tick();
      check($sformatf("t1_idle_busy_i%0d", v),  32'(d_busy),   0);
      check($sformatf("t1_idle_ready_i%0d", v), 32'(d_ready),  1);
    end

    // 2. idx 3 then 5 back-to-back; 5 parks in the slot
    d_valid = 1'b1;
    d_pri   = 3'd3;
    tick();
    check("t2_onehot_0", 32'(d_onehot), 32'(exp_t2[0]));
    check("t2_ready_slot_empty", 32'(d_ready), 1);
    d_pri = 3'd5;
    tick();
    d_valid = 1'b0;
    check("t2_ready_slot_full", 32'(d_ready), 0);
    check("t2_busy", 32'(d_busy), 1);
    for (int i = 1; i < 11; i++) begin
      check($sformatf("t2_onehot_%0d", i), 32'(d_onehot), 32'(exp_t2[i]));
      check($sformatf("t2_valid_%0d", i),  32'(d_ovalid), 32'(|exp_t2[i]));
      tick();
    end
    check("t2_end_busy", 32'(d_busy), 0);

    // 3. GAP_CYCLES=0: back-to-back grants with no dead cycle
    g_valid = 1'b1;
    g_pri   = 3'd1;
    tick();
    check("t3_onehot_0", 32'(g_onehot), 32'(exp_t3[0]));
    g_pri = 3'd6;
    tick();
    g_valid = 1'b0;
    for (int i = 1; i < 9; i++) begin
      check($sformatf("t3_onehot_%0d", i), 32'(g_onehot), 32'(exp_t3[i]));
      check($sformatf("t3_valid_%0d", i),  32'(g_ovalid), 32'(|exp_t3[i]));
      tick();
    end
    check("t3_end_busy", 32'(g_busy), 0);

    // 4. Reset in the 2nd DRIVE cycle with the slot full
    d_valid = 1'b1;
    d_pri   = 3'd3;
    tick();
    d_pri = 3'd5;
    tick();
    d_valid = 1'b0;
    check("t4_slot_full", 32'(d_ready), 0);
    rst = 1'b1;
    tick();
    check("t4_onehot", 32'(d_onehot), 0);
    check("t4_valid",  32'(d_ovalid), 0);
    check("t4_busy",   32'(d_busy),   0);
    check("t4_err",    32'(d_err),    0);
    check("t4_ready_in_rst", 32'(d_ready), 0);
    rst = 1'b0;
    tick();
    check("t4_ready_after", 32'(d_ready), 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_no_pending_%0d", i), 32'(d_onehot), 0);
      tick();
    end

    // 5. WIDTH=6: out-of-range index 7, then index 2
    w_valid = 1'b1;
    w_pri   = 3'd7;
    tick();
    w_valid = 1'b0;
    check("t5_err_pulse", 32'(w_err),    1);
    check("t5_valid",     32'(w_ovalid), 0);
    check("t5_onehot",    32'(w_onehot), 0);
    check("t5_busy",      32'(w_busy),   0);
    check("t5_ready",     32'(w_ready),  1);
    tick();
    check("t5_err_clear", 32'(w_err),    0);
    check("t5_valid_2",   32'(w_ovalid), 0);
    w_valid = 1'b1;
    w_pri   = 3'd2;
    tick();
    w_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_onehot_c%0d", k), 32'(w_onehot), 32'(6'b000100));
      check($sformatf("t5_ovalid_c%0d", k), 32'(w_ovalid), 1);
      tick();
    end
    check("t5_after", 32'(w_onehot), 0);

    // 6. Continuous random stream with a scoreboard
    run_len  = 0;
    grants   = 0;
    accepted = 0;
    cur_exp  = '0;
    for (int c = 0; c < 230; c++) begin
      if (c < 200) begin
        d_valid = 1'b1;
        d_pri   = 3'($urandom_range(0, 7));
      end else begin
        d_valid = 1'b0;
      end
      if (d_valid && d_ready) begin
        sb_q.push_back(d_pri);
        accepted++;
      end
      tick();
      check("t6_onehot0", 32'($onehot0(d_onehot)), 1);
      check("t6_valid_eq_or", 32'(d_ovalid), 32'(|d_onehot));
      if (d_ovalid) begin
        if (run_len == 0) begin
          cur_exp = (sb_q.size() > 0) ? (8'd1 << sb_q.pop_front()) : 8'h00;
          grants++;
        end
        check("t6_grant", 32'(d_onehot), 32'(cur_exp));
        run_len++;
      end else if (run_len != 0) begin
        check("t6_grant_len", run_len, 4);
        run_len = 0;
      end
    end
    check("t6_all_granted", sb_q.size(), 0);
    check("t6_grant_count", grants, accepted);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
